// File: rtl/turf_sched_pkg.sv
// Shared types and widths for the TURF HOLD scheduler.
package turf_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StCmd,
    StDead
  } sched_state_e;

  localparam int unsigned DROP_W    = 16;
  localparam int unsigned DEADCNT_W = 32;

  // Saturating increment for the dropped-trigger counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/turf_hold_scheduler_if.sv
// Trigger, CMD handshake and buffer-status signals of the HOLD scheduler.
interface turf_hold_scheduler_if
  import turf_sched_pkg::*;
#(
  parameter int unsigned NBUF = 4
);
  localparam int unsigned PtrW = $clog2(NBUF);

  logic              trig_i;
  logic              disable_i;
  logic              clr_evt_i;
  logic              clr_all_i;
  logic              cmd_ack_i;
  logic              cmd_req_o;
  logic [PtrW-1:0]   cmd_buf_o;
  logic [NBUF-1:0]   hold_o;
  logic [PtrW:0]     occupancy_o;
  logic              full_o;
  logic              busy_o;
  logic [DROP_W-1:0] dropped_o;
  logic              underflow_o;

  // Upstream side: trigger logic, readout and CMD serializer.
  modport master (
    output trig_i, disable_i, clr_evt_i, clr_all_i, cmd_ack_i,
    input  cmd_req_o, cmd_buf_o, hold_o, occupancy_o, full_o, busy_o, dropped_o, underflow_o
  );

  // Scheduler side.
  modport slave (
    input  trig_i, disable_i, clr_evt_i, clr_all_i, cmd_ack_i,
    output cmd_req_o, cmd_buf_o, hold_o, occupancy_o, full_o, busy_o, dropped_o, underflow_o
  );

endinterface

// File: rtl/turf_buf_ring.sv
// Ring of HOLD buffers: allocates at wr_ptr, releases oldest at rd_ptr, tracks occupancy.
module turf_buf_ring
  import turf_sched_pkg::*;
#(
  parameter int unsigned NBUF = 4,
  localparam int unsigned PtrW = $clog2(NBUF)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            alloc_i,
  input  logic            release_i,
  input  logic            clear_i,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [NBUF-1:0] hold_o,
  output logic [PtrW:0]   occupancy_o
);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   occ_q, occ_d;
  logic [NBUF-1:0] hold_q, hold_d;

  // Caller guarantees alloc only when not full and release only when not empty, so the
  // two pointers never address the same buffer in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    hold_d   = hold_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      hold_d   = '0;
    end else begin
      if (alloc_i) begin
        hold_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (release_i) begin
        hold_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = rd_ptr_q + 1'b1;
      end
      case ({alloc_i, release_i})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      hold_q   <= hold_d;
    end
  end

  assign wr_ptr_o    = wr_ptr_q;
  assign hold_o      = hold_q;
  assign occupancy_o = occ_q;

endmodule

// File: rtl/turf_hold_scheduler.sv
// HOLD buffer scheduler: accepts triggers into a buffer ring and sequences HOLD/setup/CMD/deadtime.
// Optional TURF_HOLD_SCHED_DEADCNT_EN adds deadtime_o, a busy-or-full cycle counter.
module turf_hold_scheduler
  import turf_sched_pkg::*;
#(
  parameter int unsigned NBUF       = 4,
  parameter int unsigned HOLD_SETUP = 8,
  parameter int unsigned DEADTIME   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  turf_hold_scheduler_if.slave bus
`ifdef TURF_HOLD_SCHED_DEADCNT_EN
  ,
  output logic [DEADCNT_W-1:0] deadtime_o
`endif
);

  localparam int unsigned PtrW = $clog2(NBUF);
  localparam logic [PtrW:0] NbufOcc = (PtrW + 1)'(NBUF);
  localparam logic [7:0] SetupLoad = 8'(HOLD_SETUP - 1);
  localparam logic [7:0] DeadLoad  = 8'((DEADTIME == 0) ? 0 : DEADTIME - 1);

  sched_state_e      state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [PtrW-1:0]   buf_q, buf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              uf_q, uf_d;

  logic [PtrW-1:0] wr_ptr;
  logic [NBUF-1:0] hold;
  logic [PtrW:0]   occupancy;
  logic            full, busy, empty;
  logic            trig_req, accept, release_evt;

  assign full     = (occupancy == NbufOcc);
  assign empty    = (occupancy == '0);
  assign busy     = (state_q != StIdle);
  assign trig_req = bus.trig_i & ~bus.disable_i;
  // Full and busy are both pre-edge values, so a same-cycle clear cannot make room.
  assign accept      = trig_req & ~bus.clr_all_i & ~busy & ~full;
  assign release_evt = bus.clr_evt_i & ~bus.clr_all_i & ~empty;

  turf_buf_ring #(
    .NBUF(NBUF)
  ) u_ring (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .alloc_i    (accept),
    .release_i  (release_evt),
    .clear_i    (bus.clr_all_i),
    .wr_ptr_o   (wr_ptr),
    .hold_o     (hold),
    .occupancy_o(occupancy)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    buf_d   = buf_q;
    if (bus.clr_all_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      req_d   = 1'b0;
      buf_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StSetup;
            cnt_d   = SetupLoad;
            buf_d   = wr_ptr;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_d = StCmd;
            req_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StCmd: begin
          if (bus.cmd_ack_i) begin
            req_d = 1'b0;
            if (DEADTIME == 0) begin
              state_d = StIdle;
            end else begin
              state_d = StDead;
              cnt_d   = DeadLoad;
            end
          end
        end
        StDead: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    uf_d   = uf_q;
    if (bus.clr_all_i) begin
      drop_d = '0;
      uf_d   = 1'b0;
    end else begin
      if (trig_req && (full || busy)) begin
        drop_d = sat_inc(drop_q);
      end
      if (bus.clr_evt_i && empty) begin
        uf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      buf_q   <= '0;
      drop_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
      uf_q    <= uf_d;
    end
  end

`ifdef TURF_HOLD_SCHED_DEADCNT_EN
  logic [DEADCNT_W-1:0] dcnt_q, dcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    if (bus.clr_all_i) begin
      dcnt_d = '0;
    end else if (busy || full) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign deadtime_o = dcnt_q;
`endif

  assign bus.cmd_req_o   = req_q;
  assign bus.cmd_buf_o   = buf_q;
  assign bus.hold_o      = hold;
  assign bus.occupancy_o = occupancy;
  assign bus.full_o      = full;
  assign bus.busy_o      = busy;
  assign bus.dropped_o   = drop_q;
  assign bus.underflow_o = uf_q;

endmodule
